// File: rtl/powlib_iptester.sv
`default_nettype none
// ============================================================================
// Module   : powlib_iptester
// Purpose  : Bus IP self-tester: writes a seeded pattern to a target, reads it
//            back with bounded outstanding reads, checks responses in any order.
// Revision : 1.0 - initial release
// ============================================================================
module powlib_iptester #(
    parameter int                B_BPD   = 4,
    parameter int                B_AW    = 32,
    parameter int                B_OPW   = 4,
    parameter logic [B_AW-1:0]   B_BASE  = 32'h50030000,
    parameter logic [B_AW-1:0]   T_BASE  = 32'h50000000,
    parameter int                WORDS   = 16,
    parameter int                MAX_OUT = 4,
    parameter logic [31:0]       SEED    = 32'hA5A5A5A5,
    parameter int                TIMEOUT = 1024,
    parameter logic [B_OPW-1:0]  OP_WR   = B_OPW'(0),
    parameter logic [B_OPW-1:0]  OP_RD   = B_OPW'(1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic                        timeout,
    output logic [15:0]                 errcnt,
    output logic [B_AW-1:0]             wraddr,
    output logic [9*B_BPD+B_OPW-1:0]    wrdata,
    output logic                        wrvld,
    input  logic                        wrrdy,
    input  logic [B_AW-1:0]             rdaddr,
    input  logic [9*B_BPD+B_OPW-1:0]    rddata,
    input  logic                        rdvld,
    output logic                        rdrdy
);

    localparam int B_DW = 8 * B_BPD;
    localparam int B_WW = B_DW + B_BPD + B_OPW;
    localparam int KW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int OW   = $clog2(MAX_OUT + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);

    localparam logic [KW-1:0]   K_LAST  = KW'(WORDS - 1);
    localparam logic [OW-1:0]   O_MAX   = OW'(MAX_OUT);
    localparam logic [TW-1:0]   T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [B_AW-1:0] BPD_A   = B_AW'(B_BPD);
    localparam logic [B_AW-1:0] WORDS_A = B_AW'(WORDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_READ   = 3'd2,
        S_DRAIN  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_start_d;
    logic [KW-1:0]   r_k;
    logic [OW-1:0]   r_out;
    logic [TW-1:0]   r_to;

    logic [B_AW-1:0] w_koff;
    logic [B_AW-1:0] w_roff;
    logic [B_AW-1:0] w_j;
    logic            w_start_edge;
    logic            w_rd_state;
    logic            w_wr_acc;
    logic            w_req_acc;
    logic            w_rsp_acc;
    logic            w_rsp_bad;
    logic            w_to_inc;
    logic            w_to_hit;
    logic [15:0]     w_errcnt_nxt;
    logic            w_unused_rsp_hdr;

    function automatic logic [B_DW-1:0] pat(input logic [B_AW-1:0] idx);
        logic [31:0] i32;
        logic [31:0] t;
        i32 = 32'(idx);
        t   = SEED ^ (i32 * 32'(B_BPD)) ^ {i32[15:0], i32[15:0]};
        return B_DW'(t);
    endfunction

    assign w_start_edge = start && !r_start_d;
    assign w_rd_state   = (r_state == S_READ) || (r_state == S_DRAIN);

    // Request channel is decoded from registered state only, so it stays
    // stable across a wrrdy stall (k and state cannot move without a beat).
    assign w_koff = B_AW'(r_k) * BPD_A;
    assign wraddr = T_BASE + w_koff;
    assign wrvld  = (r_state == S_WRITE) || ((r_state == S_READ) && (r_out < O_MAX));
    assign wrdata = (r_state == S_READ)
                  ? {OP_RD, {B_BPD{1'b1}}, B_DW'(B_BASE + w_koff)}
                  : {OP_WR, {B_BPD{1'b1}}, pat(B_AW'(r_k))};
    assign rdrdy  = w_rd_state;

    assign w_wr_acc  = wrvld && wrrdy;
    assign w_req_acc = w_wr_acc && (r_state == S_READ);
    assign w_rsp_acc = rdvld && rdrdy;

    assign w_roff    = rdaddr - B_BASE;
    assign w_j       = w_roff / BPD_A;
    assign w_rsp_bad = (w_j >= WORDS_A) || ((w_roff % BPD_A) != '0)
                    || (rddata[B_DW-1:0] != pat(w_j));
    assign w_unused_rsp_hdr = ^rddata[B_WW-1:B_DW];

    assign w_errcnt_nxt = (w_rsp_acc && w_rsp_bad && (errcnt != 16'hFFFF))
                        ? errcnt + 16'd1 : errcnt;

    assign w_to_inc = w_rd_state && (r_out != '0) && !w_rsp_acc;
    assign w_to_hit = w_to_inc && (r_to == T_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_start_d <= 1'b0;
            r_k       <= '0;
            r_out     <= '0;
            r_to      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            errcnt    <= '0;
        end else begin
            r_start_d <= start;
            errcnt    <= w_errcnt_nxt;

            if (w_req_acc && !w_rsp_acc) begin
                r_out <= r_out + OW'(1);
            end else if (!w_req_acc && w_rsp_acc && (r_out != '0)) begin
                r_out <= r_out - OW'(1);
            end

            if (w_rsp_acc) begin
                r_to <= '0;
            end else if (w_to_inc) begin
                r_to <= r_to + TW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        errcnt  <= '0;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                        timeout <= 1'b0;
                        busy    <= 1'b1;
                        r_k     <= '0;
                        r_out   <= '0;
                        r_to    <= '0;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (w_wr_acc) begin
                        if (r_k == K_LAST) begin
                            r_k     <= '0;
                            r_to    <= '0;
                            r_state <= S_READ;
                        end else begin
                            r_k <= r_k + KW'(1);
                        end
                    end
                end
                S_READ: begin
                    if (w_to_hit) begin
                        r_to    <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        timeout <= 1'b1;
                        r_state <= S_FINISH;
                    end else if (w_req_acc) begin
                        if (r_k == K_LAST) begin
                            r_k     <= '0;
                            r_to    <= '0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_k <= r_k + KW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // done rises the cycle after the final response lands
                    if (r_out == '0) begin
                        r_to    <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (w_errcnt_nxt == 16'd0);
                        r_state <= S_FINISH;
                    end else if (w_to_hit) begin
                        r_to    <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        timeout <= 1'b1;
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_powlib_iptester.sv
`default_nettype none
// ============================================================================
// Module   : tb_powlib_iptester
// Purpose  : Scoreboard bench with a loopback RAM slave for powlib_iptester.
// Revision : 1.0 - initial release
// ============================================================================
module tb_powlib_iptester;

    localparam logic [31:0] B_BASE  = 32'h50030000;
    localparam logic [31:0] T_BASE  = 32'h50000000;
    localparam logic [31:0] SEED    = 32'hA5A5A5A5;
    localparam int          WORDS   = 16;
    localparam int          MAX_OUT = 4;
    localparam int          TMO     = 64;
    localparam int          BUDGET  = 3000;

    logic        clk = 1'b0;
    logic        rst, start, busy, done, pass, timeout;
    logic [15:0] errcnt;
    logic [31:0] wraddr, rdaddr;
    logic [39:0] wrdata, rddata;
    logic        wrvld, wrrdy, rdvld, rdrdy;

    always #5 clk = ~clk;

    powlib_iptester #(
        .B_BPD(4), .B_AW(32), .B_OPW(4), .B_BASE(B_BASE), .T_BASE(T_BASE),
        .WORDS(WORDS), .MAX_OUT(MAX_OUT), .SEED(SEED), .TIMEOUT(TMO),
        .OP_WR(4'd0), .OP_RD(4'd1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .pass(pass), .timeout(timeout), .errcnt(errcnt),
        .wraddr(wraddr), .wrdata(wrdata), .wrvld(wrvld), .wrrdy(wrrdy),
        .rdaddr(rdaddr), .rddata(rddata), .rdvld(rdvld), .rdrdy(rdrdy)
    );

    typedef struct { logic [31:0] a; logic [39:0] d; } beat_t;
    typedef struct { logic [31:0] a; logic [31:0] d; int t; } rsp_t;

    beat_t       exp_q[$];
    logic [31:0] ram [16];
    int n_vec = 0;
    int n_err = 0;
    int max_out, stab_err, done_cyc, last_rsp;

    function automatic logic [31:0] pat(input int k);
        logic [31:0] kk;
        kk = 32'(k);
        return SEED ^ (kk * 32'd4) ^ {kk[15:0], kk[15:0]};
    endfunction

    // Pulses start and loads the scoreboard with the expected request stream.
    task automatic start_test();
        repeat (2) @(negedge clk);
        exp_q.delete();
        for (int k = 0; k < WORDS; k++)
            exp_q.push_back('{a: T_BASE + 32'(4 * k), d: {4'h0, 4'hF, pat(k)}});
        for (int k = 0; k < WORDS; k++)
            exp_q.push_back('{a: T_BASE + 32'(4 * k), d: {4'h1, 4'hF, B_BASE + 32'(4 * k)}});
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Slave model; entered at a negedge, returns at the negedge where done is seen.
    task automatic drive_slave(input bit corrupt, input bit rev, input bit stall,
                               input int drop_idx, input bit spurious, input int lat,
                               input bit rst_at3, input int start_at);
        rsp_t        pend[$];
        rsp_t        rel[$];
        rsp_t        cur;
        beat_t       b;
        logic        cur_v, hold_v, wr_acc, rd_acc, got;
        logic [31:0] hold_a, off;
        logic [39:0] hold_d;
        int          nreq, nout, idx;
        cur_v = 1'b0; hold_v = 1'b0; got = 1'b0;
        hold_a = '0; hold_d = '0;
        nreq = 0; nout = 0;
        max_out = 0; stab_err = 0; done_cyc = -1; last_rsp = -1;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                got = 1'b1;
                break;
            end
            if (hold_v && wrvld && (wraddr !== hold_a || wrdata !== hold_d))
                stab_err++;
            start = (cyc == start_at);
            if (rst_at3 && nout == 3 && rdrdy && nreq < WORDS) begin
                rst = 1'b1; wrrdy = 1'b0; rdvld = 1'b0;
                return;
            end
            wrrdy = stall ? ($urandom_range(0, 99) < 60) : 1'b1;
            if (!cur_v) begin
                if (rev) begin
                    if (rel.size() == 0 && pend.size() > 0 && (pend.size() == 4 || nreq == WORDS))
                        while (pend.size() > 0) rel.push_back(pend.pop_back());
                    if (rel.size() > 0 && (!stall || $urandom_range(0, 1) == 1)) begin
                        cur = rel.pop_front(); cur_v = 1'b1;
                    end
                end else if (pend.size() > 0 && pend[0].t <= cyc &&
                             (!stall || $urandom_range(0, 1) == 1)) begin
                    cur = pend.pop_front(); cur_v = 1'b1;
                end
            end
            rdvld = cur_v; rdaddr = cur.a; rddata = {4'h0, 4'hF, cur.d};
            wr_acc = wrvld && wrrdy;
            rd_acc = cur_v && rdrdy;
            if (wr_acc) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL bus_beat: got addr=%h data=%h, required no further beat", wraddr, wrdata);
                end else begin
                    b = exp_q.pop_front();
                    if (wraddr !== b.a || wrdata !== b.d) begin
                        n_err++;
                        $display("FAIL bus_beat: got addr=%h data=%h, required addr=%h data=%h",
                                 wraddr, wrdata, b.a, b.d);
                    end
                end
                off = wraddr - T_BASE;
                idx = int'(off[5:2]);
                if (wrdata[39:36] == 4'h0) begin
                    ram[idx] = wrdata[31:0] ^ ((corrupt && idx == 5) ? 32'h1 : 32'h0);
                end else begin
                    nreq++; nout++;
                    if (nreq - 1 != drop_idx)
                        pend.push_back('{a: wrdata[31:0], d: ram[idx], t: cyc + lat});
                    if (spurious && nreq == WORDS)
                        pend.push_front('{a: B_BASE + 32'd64, d: 32'h0, t: 0});
                end
            end
            if (rd_acc) begin
                cur_v = 1'b0; nout--; last_rsp = cyc;
            end
            if (nout > max_out) max_out = nout;
            hold_v = wrvld && !wrrdy; hold_a = wraddr; hold_d = wrdata;
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0; rdvld = 1'b0; wrrdy = 1'b0;
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL done_wait: done not seen within %0d cycles, required done=1", BUDGET);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({busy, done, pass, timeout, wrvld, rdrdy, errcnt} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b pass=%b tmo=%b wrvld=%b rdrdy=%b errcnt=%0d, required all 0",
                     busy, done, pass, timeout, wrvld, rdrdy, errcnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_loopback();
        start_test();
        n_vec++;
        if (wrvld !== 1'b1 || busy !== 1'b1 || wraddr !== T_BASE) begin
            n_err++;
            $display("FAIL first_write_latency: got wrvld=%b busy=%b addr=%h, required 1 1 %h",
                     wrvld, busy, wraddr, T_BASE);
        end
        drive_slave(0, 0, 0, -1, 0, 6, 0, -1);
        n_vec++;
        if (pass !== 1'b1 || errcnt !== 16'd0 || timeout !== 1'b0) begin
            n_err++;
            $display("FAIL loop_result: got pass=%b errcnt=%0d tmo=%b, required 1 0 0", pass, errcnt, timeout);
        end
        n_vec++;
        if (max_out != MAX_OUT) begin
            n_err++;
            $display("FAIL loop_max_out: got %0d, required %0d", max_out, MAX_OUT);
        end
        n_vec++;
        if (done_cyc - last_rsp != 2) begin
            n_err++;
            $display("FAIL done_latency: got %0d, required 2", done_cyc - last_rsp);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL loop_beats_left: got %0d, required 0", exp_q.size());
        end
        repeat (5) @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1) begin
            n_err++;
            $display("FAIL status_hold: got done=%b busy=%b pass=%b, required 1 0 1", done, busy, pass);
        end
    endtask

    task automatic test_corrupt();
        start_test();
        drive_slave(1, 0, 0, -1, 0, 4, 0, -1);
        n_vec++;
        if (done !== 1'b1 || pass !== 1'b0 || errcnt !== 16'd1 || timeout !== 1'b0) begin
            n_err++;
            $display("FAIL corrupt_result: got done=%b pass=%b errcnt=%0d tmo=%b, required 1 0 1 0",
                     done, pass, errcnt, timeout);
        end
    endtask

    task automatic test_back_to_back_reverse();
        start_test();
        drive_slave(0, 1, 1, -1, 0, 0, 0, -1);
        n_vec++;
        if (pass !== 1'b1 || errcnt !== 16'd0) begin
            n_err++;
            $display("FAIL reverse_result: got pass=%b errcnt=%0d, required 1 0", pass, errcnt);
        end
        n_vec++;
        if (stab_err != 0) begin
            n_err++;
            $display("FAIL stall_stability: got %0d changes, required 0", stab_err);
        end
        n_vec++;
        if (max_out > MAX_OUT) begin
            n_err++;
            $display("FAIL reverse_max_out: got %0d, required <= %0d", max_out, MAX_OUT);
        end
    endtask

    task automatic test_timeout();
        start_test();
        drive_slave(0, 0, 0, 9, 0, 3, 0, -1);
        n_vec++;
        if (timeout !== 1'b1 || pass !== 1'b0 || done !== 1'b1 || errcnt !== 16'd0) begin
            n_err++;
            $display("FAIL timeout_result: got tmo=%b pass=%b done=%b errcnt=%0d, required 1 0 1 0",
                     timeout, pass, done, errcnt);
        end
        n_vec++;
        if (done_cyc - last_rsp != TMO + 1) begin
            n_err++;
            $display("FAIL timeout_latency: got %0d, required %0d", done_cyc - last_rsp, TMO + 1);
        end
    endtask

    task automatic test_reset_midread();
        logic bad;
        start_test();
        drive_slave(0, 0, 0, -1, 0, 6, 1, -1);
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({busy, done, pass, timeout, wrvld, rdrdy, errcnt} !== 22'd0) begin
            n_err++;
            $display("FAIL midread_reset: got busy=%b done=%b pass=%b tmo=%b wrvld=%b rdrdy=%b errcnt=%0d, required all 0",
                     busy, done, pass, timeout, wrvld, rdrdy, errcnt);
        end
        rst = 1'b0;
        rdvld = 1'b1; rdaddr = B_BASE; rddata = {4'h0, 4'hF, pat(0)};
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rdrdy !== 1'b0) bad = 1'b1;
        end
        rdvld = 1'b0;
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL stale_response: got rdrdy=1 after reset, required 0");
        end
        start_test();
        drive_slave(0, 0, 0, -1, 0, 6, 0, -1);
        n_vec++;
        if (pass !== 1'b1 || errcnt !== 16'd0 || max_out != MAX_OUT) begin
            n_err++;
            $display("FAIL post_reset_run: got pass=%b errcnt=%0d max_out=%0d, required 1 0 %0d",
                     pass, errcnt, max_out, MAX_OUT);
        end
    endtask

    task automatic test_spurious();
        start_test();
        drive_slave(0, 0, 0, -1, 1, 6, 0, 20);
        n_vec++;
        if (errcnt !== 16'd1 || pass !== 1'b0 || timeout !== 1'b0 || done !== 1'b1) begin
            n_err++;
            $display("FAIL spurious_result: got errcnt=%0d pass=%b tmo=%b done=%b, required 1 0 0 1",
                     errcnt, pass, timeout, done);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL busy_start_ignored: got %0d beats left, required 0", exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; wrrdy = 1'b0; rdvld = 1'b0;
        rdaddr = '0; rddata = '0;
        for (int i = 0; i < 16; i++) ram[i] = '0;
        test_reset();
        test_loopback();
        test_corrupt();
        test_back_to_back_reverse();
        test_timeout();
        test_reset_midread();
        test_spurious();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/powlib_iptester.md
POWLIB_IPTESTER -- requirements
Module: powlib_iptester

Interface
REQ-001 Parameters SHALL be: B_BPD 4, bytes per data word; B_AW 32, address width; B_OPW 4, bus op width; B_BASE 32'h50030000, own return base address; T_BASE 32'h50000000, target base address; WORDS 16, words per test (1..1024); MAX_OUT 4, maximum outstanding reads (1..16); SEED 32'hA5A5A5A5, pattern seed; TIMEOUT 1024, idle-response cycles before abort; OP_WR 0, write op code; OP_RD 1, read-request op code.
REQ-002 Derived: B_DW = 8*B_BPD; B_WW = B_DW + B_BPD + B_OPW; packed word = {op, be, data}, data in the LSBs.
REQ-003 Clock and reset SHALL be a single clock and a synchronous, active-high reset: clk in 1, clock; rst in 1, synchronous active-high reset.
REQ-004 Control ports SHALL be:
- start in 1, rising-edge test start
- busy out 1, test running
- done out 1, test finished, held until next start
- pass out 1, valid while done
- timeout out 1, valid while done
- errcnt out 16, saturating mismatch count
REQ-005 Bus request ports SHALL be: wraddr out B_AW; wrdata out B_WW; wrvld out 1; wrrdy in 1.
REQ-006 Bus response ports SHALL be: rdaddr in B_AW; rddata in B_WW; rdvld in 1; rdrdy out 1.

Function
REQ-007 Transfers SHALL occur on cycles where vld&rdy are both high; wraddr/wrdata SHALL be stable while wrvld=1 and wrrdy=0.
REQ-008 Pattern for word k SHALL be P(k) = SEED ^ (k*B_BPD) ^ {k[15:0],k[15:0]}, truncated to B_DW bits.
REQ-009 The FSM SHALL have states IDLE, WRITE, READ, DRAIN, FINISH.
REQ-010 IDLE: a start 0->1 edge SHALL clear errcnt, done, pass, timeout and k, assert busy, and enter WRITE on the next cycle.
REQ-011 WRITE: wraddr = T_BASE + k*B_BPD, wrdata = {OP_WR, all-ones be, P(k)}, wrvld=1; k increments per accepted beat; after beat WORDS-1 is accepted, k clears and the FSM enters READ.
REQ-012 READ: wraddr = T_BASE + k*B_BPD, wrdata = {OP_RD, all-ones be, B_BASE + k*B_BPD}. wrvld SHALL be 1 only while outstanding < MAX_OUT. After the last request is accepted, the FSM enters DRAIN.
REQ-013 Outstanding counter: +1 on read-request accept, -1 on response accept; a simultaneous accept SHALL leave it unchanged; it SHALL never exceed MAX_OUT.
REQ-014 rdrdy SHALL be 1 in READ and DRAIN, and 0 in all other states.
REQ-015 Response check, order-independent: j = (rdaddr - B_BASE)/B_BPD.
- errcnt += 1 (saturating at 16'hFFFF) if j >= WORDS, rdaddr is misaligned, or rddata data field != P(j).
- Responses arriving outside READ/DRAIN are not accepted.
REQ-016 DRAIN SHALL enter FINISH when outstanding reaches 0.
REQ-017 Timeout counter: clears on every response accept and on every state change; increments while in READ/DRAIN with outstanding > 0. On reaching TIMEOUT it SHALL set timeout=1 and enter FINISH.
REQ-018 FINISH (one cycle): busy=0, done=1, pass = (errcnt==0 && !timeout); then IDLE. done/pass/timeout/errcnt SHALL hold until the next start edge.
REQ-019 A start edge while busy SHALL be ignored.
REQ-020 Latency: first write SHALL be presented 1 cycle after the start edge; done SHALL be asserted 1 cycle after the last response is accepted.

Reset
REQ-021 rst SHALL force, on the next clk edge: IDLE; wrvld=0, rdrdy=0, busy=0, done=0, pass=0, timeout=0, errcnt=0; outstanding=0, k=0, timeout counter=0, start-edge register=0.
REQ-022 rst mid-test SHALL abandon outstanding reads; stale responses after reset SHALL not be accepted until the next test's READ state.

Verification
REQ-023 Loopback RAM model, WORDS=16, MAX_OUT=4, wrrdy=1: pulse start -> 16 writes, 16 reads, done=1, pass=1, errcnt=0, at most 4 outstanding reads at any time.
REQ-024 RAM model corrupts word 5 (bit 0 flipped) -> done=1, pass=0, errcnt=1.
REQ-025 Slave returns the 4 responses per window in reverse order, with random wrrdy/rdvld stalls -> pass=1; wraddr/wrdata stable during stalls.
REQ-026 Slave drops the 10th read, TIMEOUT=64 -> timeout=1, pass=0, done 64 cycles after the last response.
REQ-027 rst asserted during READ with 3 outstanding -> all outputs at reset values next cycle; a new start then completes with pass=1.
REQ-028 Spurious response at rdaddr = B_BASE+16*4 during DRAIN -> errcnt=1, pass=0; start pulsed while busy has no effect.
